// File: rtl/move_mailbox_reader.sv
// Polls two mailbox words in data memory (move-right / move-left flags),
// clears any nonzero flag and turns it into a pending move event for a
// consumer. Overflowing events are counted in a saturating drop counter.
//
// state | meaning
// IDLE  | bus released, idle down-counter running to the next sweep
// REQ   | requesting the memory port, waiting for grant
// RD_R  | presenting the right-flag address for a read
// CHK_R | right-flag read data valid, decide clear or move on
// CLR_R | writing 0 to the right flag, raising the right pending flag
// RD_L  | presenting the left-flag address for a read
// CHK_L | left-flag read data valid, decide clear or finish
// CLR_L | writing 0 to the left flag, raising the left pending flag
module move_mailbox_reader #(
  parameter int POLL_CYCLES = 1000,
  parameter int RIGHT_ADDR  = 205,
  parameter int LEFT_ADDR   = 206
) (
  input  logic        clock,
  input  logic        reset,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [11:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        evt_valid,
  output logic        evt_dir,
  input  logic        evt_ready,
  output logic [7:0]  drop_cnt
);

  localparam int              CW     = (POLL_CYCLES < 2) ? 1 : $clog2(POLL_CYCLES + 1);
  localparam logic [CW-1:0]   C_LOAD = CW'(POLL_CYCLES);
  localparam logic [11:0]     C_ADDR_R = 12'(RIGHT_ADDR);
  localparam logic [11:0]     C_ADDR_L = 12'(LEFT_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD_R, S_CHK_R, S_CLR_R, S_RD_L, S_CHK_L, S_CLR_L
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_idle_cnt;
  logic            r_resume_l;
  logic            r_right_pend;
  logic            r_left_pend;
  logic [7:0]      r_drop_cnt;

  logic            w_req;
  logic            w_wen;
  logic [11:0]     w_addr;
  logic            w_set_r;
  logic            w_set_l;
  logic            w_idle_tc;
  logic            w_xfer;
  logic            w_xfer_r;
  logic            w_xfer_l;
  logic            w_drop;

  assign w_idle_tc = (r_idle_cnt <= CW'(1));

  // State register; reset forces IDLE so bus_req/mem_wen drop immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and memory-port outputs; a lost grant always falls back to REQ.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_wen       = 1'b0;
    w_addr      = '0;
    w_set_r     = 1'b0;
    w_set_l     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_idle_tc) w_state_nxt = S_REQ;
      S_REQ: begin
        w_req = 1'b1;
        if (bus_gnt) w_state_nxt = r_resume_l ? S_RD_L : S_RD_R;
      end
      S_RD_R: begin
        w_req = 1'b1;
        if (!bus_gnt) w_state_nxt = S_REQ;
        else begin
          w_addr      = C_ADDR_R;
          w_state_nxt = S_CHK_R;
        end
      end
      S_CHK_R: begin
        w_req = 1'b1;
        if (!bus_gnt)              w_state_nxt = S_REQ;
        else if (mem_rdata != '0)  w_state_nxt = S_CLR_R;
        else                       w_state_nxt = S_RD_L;
      end
      S_CLR_R: begin
        w_req = 1'b1;
        if (!bus_gnt) w_state_nxt = S_REQ;
        else begin
          w_addr      = C_ADDR_R;
          w_wen       = 1'b1;
          w_set_r     = 1'b1;
          w_state_nxt = S_RD_L;
        end
      end
      S_RD_L: begin
        w_req = 1'b1;
        if (!bus_gnt) w_state_nxt = S_REQ;
        else begin
          w_addr      = C_ADDR_L;
          w_state_nxt = S_CHK_L;
        end
      end
      S_CHK_L: begin
        w_req = 1'b1;
        if (!bus_gnt)              w_state_nxt = S_REQ;
        else if (mem_rdata != '0)  w_state_nxt = S_CLR_L;
        else                       w_state_nxt = S_IDLE;
      end
      S_CLR_L: begin
        w_req = 1'b1;
        if (!bus_gnt) w_state_nxt = S_REQ;
        else begin
          w_addr      = C_ADDR_L;
          w_wen       = 1'b1;
          w_set_l     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Idle down-counter, reloaded whenever a sweep finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                        r_idle_cnt <= C_LOAD;
    else if (w_state_nxt == S_IDLE && r_state != S_IDLE) r_idle_cnt <= C_LOAD;
    else if (r_state == S_IDLE && r_idle_cnt != '0)   r_idle_cnt <= r_idle_cnt - CW'(1);
  end

  // Remembers which flag to resume at after a grant loss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        r_resume_l <= 1'b0;
    else if (w_state_nxt == S_RD_L)   r_resume_l <= 1'b1;
    else if (w_state_nxt == S_IDLE)   r_resume_l <= 1'b0;
  end

  assign w_xfer   = evt_valid & evt_ready;
  assign w_xfer_l = w_xfer & r_left_pend;
  assign w_xfer_r = w_xfer & ~r_left_pend & r_right_pend;
  assign w_drop   = (w_set_l & r_left_pend  & ~w_xfer_l) |
                    (w_set_r & r_right_pend & ~w_xfer_r);

  // Pending flags: a new set wins over a same-cycle transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_right_pend <= 1'b0;
      r_left_pend  <= 1'b0;
    end else begin
      if (w_set_r)       r_right_pend <= 1'b1;
      else if (w_xfer_r) r_right_pend <= 1'b0;
      if (w_set_l)       r_left_pend  <= 1'b1;
      else if (w_xfer_l) r_left_pend  <= 1'b0;
    end
  end

  // Saturating count of events overwritten while still pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign bus_req   = w_req;
  assign mem_wen   = w_wen;
  assign mem_addr  = w_addr;
  assign mem_wdata = '0;
  assign evt_valid = r_left_pend | r_right_pend;
  assign evt_dir   = r_left_pend;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_move_mailbox_reader.sv
// Bench for move_mailbox_reader: two-word mailbox memory model, event
// monitor feeding an observed queue, expected events queued at stimulus.
module tb_move_mailbox_reader;

  localparam int P = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_req;
  logic        bus_gnt;
  logic [11:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        evt_valid;
  logic        evt_dir;
  logic        evt_ready;
  logic [7:0]  drop_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [31:0] word_r = '0;
  logic [31:0] word_l = '0;
  int wr_r = 0, wr_l = 0;
  int set_r_req = 0, set_r_seen = 0;
  int set_l_req = 0, set_l_seen = 0;

  bit exp_q[$];
  bit obs_q[$];
  int obs_cyc[$];

  move_mailbox_reader #(.POLL_CYCLES(P), .RIGHT_ADDR(205), .LEFT_ADDR(206)) dut (
    .clock(clock), .reset(reset), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .evt_valid(evt_valid), .evt_dir(evt_dir),
    .evt_ready(evt_ready), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory with one-cycle read latency; mailbox words are set by request counters.
  always @(posedge clock) begin
    mem_rdata <= (mem_addr == 12'd205) ? word_r : (mem_addr == 12'd206) ? word_l : 32'h0;
    if (mem_wen && mem_addr == 12'd205) begin
      word_r <= mem_wdata;
      wr_r   <= wr_r + 1;
    end else if (set_r_req != set_r_seen) begin
      word_r     <= 32'h1;
      set_r_seen <= set_r_req;
    end
    if (mem_wen && mem_addr == 12'd206) begin
      word_l <= mem_wdata;
      wr_l   <= wr_l + 1;
    end else if (set_l_req != set_l_seen) begin
      word_l     <= 32'h1;
      set_l_seen <= set_l_req;
    end
  end

  // Event monitor: every accepted transfer is logged with its cycle.
  always @(negedge clock) begin
    if (!reset && evt_valid && evt_ready) begin
      obs_q.push_back(evt_dir);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_sweep_end(input string tag);
    int n = 0;
    while (bus_req !== 1'b1 && n < 100) begin tick(); n++; end
    while (bus_req !== 1'b0 && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      n_total++;
      $display("FAIL %s_sweep: got timeout want sweep end", tag);
    end
  endtask

  task automatic wait_access(input logic [11:0] a, input logic wen, input string tag, output int t);
    int n = 0;
    while (!(mem_addr === a && mem_wen === wen && bus_req === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    t = cyc;
    if (n >= 100) begin
      n_total++;
      $display("FAIL %s_access: got timeout want addr %0d wen %0b", tag, a, wen);
    end
  endtask

  task automatic drain();
    int n = 0;
    evt_ready = 1'b1;
    while (evt_valid === 1'b1 && n < 20) begin tick(); n++; end
    evt_ready = 1'b0;
    if (n >= 20) begin
      n_total++;
      $display("FAIL drain: got evt_valid stuck want 0");
    end
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1'b1; bus_gnt = 1'b1; evt_ready = 1'b0;
    #1;
    n_total++; if (bus_req !== 1'b0)  $display("FAIL rst_bus_req: got %0b want 0", bus_req); else n_pass++;
    n_total++; if (mem_wen !== 1'b0)  $display("FAIL rst_mem_wen: got %0b want 0", mem_wen); else n_pass++;
    n_total++; if (mem_addr !== 12'd0) $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'd0) $display("FAIL rst_mem_wdata: got %0h want 0", mem_wdata); else n_pass++;
    n_total++; if (evt_valid !== 1'b0 || evt_dir !== 1'b0) $display("FAIL rst_evt: got %0b%0b want 00", evt_valid, evt_dir); else n_pass++;
    n_total++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop: got %0d want 0", drop_cnt); else n_pass++;
    tick(); tick();
    reset = 1'b0;
    while (bus_req !== 1'b1 && n < 50) begin tick(); n++; end
    n_total++; if (n !== P) $display("FAIL rst_first_req: got %0d cycles want %0d", n, P); else n_pass++;
  endtask

  task automatic test_right_single();
    int t, w0;
    bit e, o;
    wait_sweep_end("single");
    w0 = wr_r;
    set_r_req++;
    exp_q.push_back(1'b0);
    wait_access(12'd205, 1'b0, "single_rd", t);
    tick();
    n_total++; if (mem_addr !== 12'd0 || mem_wen !== 1'b0) $display("FAIL single_chk: got addr %0d wen %0b want 0 0", mem_addr, mem_wen); else n_pass++;
    tick();
    n_total++; if (mem_addr !== 12'd205 || mem_wen !== 1'b1 || mem_wdata !== 32'd0) $display("FAIL single_clr: got addr %0d wen %0b wdata %0h want 205 1 0", mem_addr, mem_wen, mem_wdata); else n_pass++;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL single_early_evt: got %0b want 0", evt_valid); else n_pass++;
    tick();
    n_total++; if (evt_valid !== 1'b1 || evt_dir !== 1'b0) $display("FAIL single_evt: got valid %0b dir %0b want 1 0", evt_valid, evt_dir); else n_pass++;
    n_total++; if (mem_addr !== 12'd206 || mem_wen !== 1'b0) $display("FAIL single_rd_l: got addr %0d wen %0b want 206 0", mem_addr, mem_wen); else n_pass++;
    wait_sweep_end("single2");
    n_total++; if (word_r !== 32'd0 || wr_r - w0 !== 1) $display("FAIL single_mem: got word %0h writes %0d want 0 1", word_r, wr_r - w0); else n_pass++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL single_sb: got none want dir %0b", e);
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) $display("FAIL single_sb: got dir %0b want %0b", o, e); else n_pass++; end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL single_extra: got %0d want 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_both();
    bit e, o;
    int c0, c1;
    wait_sweep_end("both");
    set_r_req++; set_l_req++;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    wait_sweep_end("both2");
    n_total++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1) $display("FAIL both_prio: got valid %0b dir %0b want 1 1", evt_valid, evt_dir); else n_pass++;
    n_total++; if (word_r !== 32'd0 || word_l !== 32'd0) $display("FAIL both_mem: got %0h %0h want 0 0", word_r, word_l); else n_pass++;
    drain();
    n_total++;
    if (obs_cyc.size() < 2) $display("FAIL both_count: got %0d want 2", obs_cyc.size());
    else begin
      c0 = obs_cyc[0]; c1 = obs_cyc[1];
      if (c1 - c0 !== 1) $display("FAIL both_consec: got gap %0d want 1", c1 - c0); else n_pass++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL both_sb: got none want dir %0b", e);
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) $display("FAIL both_sb: got dir %0b want %0b", o, e); else n_pass++; end
    end
    n_total++; if (drop_cnt !== 8'd0) $display("FAIL both_drop: got %0d want 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_overflow();
    bit e, o;
    for (int k = 0; k < 3; k++) begin
      wait_sweep_end("ovf");
      set_l_req++;
      if (k == 0) exp_q.push_back(1'b1);
      wait_sweep_end("ovf2");
      n_total++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1) $display("FAIL ovf_evt%0d: got valid %0b dir %0b want 1 1", k, evt_valid, evt_dir); else n_pass++;
      n_total++; if (drop_cnt !== 8'(k)) $display("FAIL ovf_drop%0d: got %0d want %0d", k, drop_cnt, k); else n_pass++;
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL ovf_sb: got none want dir %0b", e);
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) $display("FAIL ovf_sb: got dir %0b want %0b", o, e); else n_pass++; end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL ovf_extra: got %0d want 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_gnt_drop();
    int t, w0, bad;
    bit e, o;
    wait_sweep_end("gnt");
    w0 = wr_r;
    set_r_req++;
    exp_q.push_back(1'b0);
    wait_access(12'd205, 1'b0, "gnt_rd", t);
    tick();
    tick();
    bus_gnt = 1'b0;
    #1;
    n_total++; if (mem_wen !== 1'b0 || mem_addr !== 12'd0) $display("FAIL gnt_nowrite: got wen %0b addr %0d want 0 0", mem_wen, mem_addr); else n_pass++;
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (mem_wen !== 1'b0 || bus_req !== 1'b1) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL gnt_hold: got %0d bad cycles want 0", bad); else n_pass++;
    tick();
    n_total++; if (word_r !== 32'd1) $display("FAIL gnt_word_kept: got %0h want 1", word_r); else n_pass++;
    bus_gnt = 1'b1;
    wait_access(12'd205, 1'b0, "gnt_reread", t);
    wait_sweep_end("gnt2");
    n_total++; if (word_r !== 32'd0 || wr_r - w0 !== 1) $display("FAIL gnt_clear: got word %0h writes %0d want 0 1", word_r, wr_r - w0); else n_pass++;
    n_total++; if (evt_valid !== 1'b1 || evt_dir !== 1'b0) $display("FAIL gnt_evt: got valid %0b dir %0b want 1 0", evt_valid, evt_dir); else n_pass++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL gnt_sb: got none want dir %0b", e);
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) $display("FAIL gnt_sb: got dir %0b want %0b", o, e); else n_pass++; end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL gnt_extra: got %0d want 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_collide();
    int t;
    bit e, o;
    wait_sweep_end("col");
    set_l_req++;
    exp_q.push_back(1'b1);
    wait_sweep_end("col2");
    n_total++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1) $display("FAIL col_pend: got valid %0b dir %0b want 1 1", evt_valid, evt_dir); else n_pass++;
    set_l_req++;
    exp_q.push_back(1'b1);
    wait_access(12'd206, 1'b1, "col_clr", t);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_total++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1) $display("FAIL col_keep: got valid %0b dir %0b want 1 1", evt_valid, evt_dir); else n_pass++;
    n_total++; if (drop_cnt !== 8'd2) $display("FAIL col_drop: got %0d want 2", drop_cnt); else n_pass++;
    n_total++; if (obs_q.size() != 1) $display("FAIL col_xfer: got %0d transfers want 1", obs_q.size()); else n_pass++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL col_sb: got none want dir %0b", e);
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) $display("FAIL col_sb: got dir %0b want %0b", o, e); else n_pass++; end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL col_extra: got %0d want 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_reset_clr();
    int t, n;
    bit e, o;
    wait_sweep_end("rclr");
    set_l_req++;
    exp_q.push_back(1'b1);
    wait_access(12'd206, 1'b1, "rclr_clr", t);
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (mem_wen !== 1'b0 || bus_req !== 1'b0) $display("FAIL rclr_async: got wen %0b req %0b want 0 0", mem_wen, bus_req); else n_pass++;
    n_total++; if (evt_valid !== 1'b0 || mem_addr !== 12'd0) $display("FAIL rclr_out: got valid %0b addr %0d want 0 0", evt_valid, mem_addr); else n_pass++;
    n_total++; if (drop_cnt !== 8'd0) $display("FAIL rclr_drop: got %0d want 0", drop_cnt); else n_pass++;
    tick(); tick();
    reset = 1'b0;
    n = 0;
    while (bus_req !== 1'b1 && n < 50) begin tick(); n++; end
    n_total++; if (n !== P) $display("FAIL rclr_first_req: got %0d cycles want %0d", n, P); else n_pass++;
    wait_sweep_end("rclr2");
    n_total++; if (word_l !== 32'd0) $display("FAIL rclr_mem: got %0h want 0", word_l); else n_pass++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_q.size() == 0) $display("FAIL rclr_sb: got none want dir %0b", e);
      else begin o = obs_q.pop_front(); void'(obs_cyc.pop_front());
        if (o !== e) $display("FAIL rclr_sb: got dir %0b want %0b", o, e); else n_pass++; end
    end
    n_total++; if (obs_q.size() != 0) $display("FAIL rclr_extra: got %0d want 0", obs_q.size()); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_right_single();
    test_both();
    test_overflow();
    test_gnt_drop();
    test_collide();
    test_reset_clr();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
